// File: rtl/param_serializer.sv
// Parallel-to-serial converter: WIDTH-bit words in over valid/ready, one bit out per bit_en strobe,
// with first/last markers, gapless back-to-back words and a synchronous flush.
module param_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  input  logic             bit_en,
  input  logic             flush,
  output logic             ser_o,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("param_serializer: WIDTH must be at least 2");
    end
  endgenerate

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_q, ser_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_first_q, ser_first_d;
  logic             ser_last_q, ser_last_d;
  logic             par_ready_s;
  logic             transfer_s;

  // A new word may enter while idle, or on the strobe that emits the current word's last bit.
  always_comb begin
    par_ready_s = !flush && ((state_q == S_IDLE) ||
                             ((state_q == S_SHIFT) && bit_en && (cnt_q == LAST_CNT)));
    transfer_s  = par_valid && par_ready_s;
  end

  // Next-state and next-output logic; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ser_d       = ser_q;
    ser_valid_d = 1'b0;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ser_d   = IDLE_LEVEL;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bit_en) begin
            ser_d = IDLE_LEVEL;
          end else begin
            ser_d = ser_q;
          end
        end
        S_SHIFT: begin
          if (bit_en) begin
            if (MSB_FIRST) begin
              ser_d   = shreg_q[WIDTH-1];
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
              ser_d   = shreg_q[0];
              shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            ser_valid_d = 1'b1;
            ser_first_d = (cnt_q == '0);
            ser_last_d  = (cnt_q == LAST_CNT);
            if (cnt_q != LAST_CNT) begin
              cnt_d = cnt_q + CW'(1'b1);
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            ser_d = ser_q;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
      // A load on the last-bit strobe keeps SHIFT so the next strobe emits bit 0 with no gap.
      if (transfer_s) begin
        shreg_d = par_data;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end else begin
        shreg_d = shreg_d;
      end
    end
  end

  // State, shift register, counter and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ser_q       <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ser_q       <= ser_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign par_ready = par_ready_s;
  assign ser_o     = ser_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign busy      = (state_q == S_SHIFT);

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: an MSB-first instance (idle 0) and an LSB-first instance (idle 1) share
// stimulus and are compared against a word/bit-index reference model plus fixed expectations.
module tb_param_serializer;
  localparam int W = 8;

  logic clk, rst_n;
  logic [W-1:0] par_data;
  logic par_valid, bit_en, flush;
  logic par_ready_a, ser_o_a, ser_valid_a, ser_first_a, ser_last_a, busy_a;
  logic par_ready_b, ser_o_b, ser_valid_b, ser_first_b, ser_last_b, busy_b;

  param_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .par_data(par_data), .par_valid(par_valid), .par_ready(par_ready_a),
    .bit_en(bit_en), .flush(flush), .ser_o(ser_o_a), .ser_valid(ser_valid_a),
    .ser_first(ser_first_a), .ser_last(ser_last_a), .busy(busy_a));

  param_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .par_data(par_data), .par_valid(par_valid), .par_ready(par_ready_b),
    .bit_en(bit_en), .flush(flush), .ser_o(ser_o_b), .ser_valid(ser_valid_b),
    .ser_first(ser_first_b), .ser_last(ser_last_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: the word in flight and how many of its bits have gone out.
  bit         m_active;
  logic [7:0] m_word;
  int         m_sent;
  logic e_ser_a, e_ser_b, e_valid, e_first, e_last, e_ready;
  logic [1:0] got_ready;
  logic [15:0] col_a, col_b;
  int n_valid, n_first, n_last;

  task automatic model_reset();
    m_active = 1'b0; m_word = 8'h00; m_sent = 0;
    e_ser_a = 1'b0; e_ser_b = 1'b1; e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0;
  endtask

  task automatic clear_collect();
    col_a = 16'h0000; col_b = 16'h0000; n_valid = 0; n_first = 0; n_last = 0;
  endtask

  function automatic logic [9:0] exp_vec();
    return {e_ser_a, e_ser_b, e_valid, e_valid, e_first, e_first, e_last, e_last, m_active, m_active};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {ser_o_a, ser_o_b, ser_valid_a, ser_valid_b, ser_first_a, ser_first_b,
            ser_last_a, ser_last_b, busy_a, busy_b};
  endfunction

  // Applies one cycle of inputs, advances the model across the edge and records serial activity.
  task automatic clk_cycle(input logic v, input logic [7:0] d, input logic be, input logic fl);
    par_valid = v; par_data = d; bit_en = be; flush = fl;
    #1;
    e_ready = !fl && (!m_active || (be && m_sent == W - 1));
    got_ready = {par_ready_a, par_ready_b};
    @(posedge clk);
    e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0;
    if (fl) begin
      m_active = 1'b0; m_sent = 0; e_ser_a = 1'b0; e_ser_b = 1'b1;
    end else begin
      if (m_active && be) begin
        e_ser_a = m_word[W-1-m_sent];
        e_ser_b = m_word[m_sent];
        e_valid = 1'b1;
        e_first = (m_sent == 0);
        e_last  = (m_sent == W - 1);
        m_sent++;
        if (m_sent == W) m_active = 1'b0;
      end else if (!m_active && be) begin
        e_ser_a = 1'b0; e_ser_b = 1'b1;
      end
      if (v && e_ready) begin
        m_word = d; m_sent = 0; m_active = 1'b1;
      end
    end
    #1;
    if (ser_valid_a) begin
      col_a = {col_a[14:0], ser_o_a};
      n_valid++;
      if (ser_first_a) n_first++;
      if (ser_last_a) n_last++;
    end
    if (ser_valid_b) col_b = {col_b[14:0], ser_o_b};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; par_valid = 1'b0; par_data = 8'h00; bit_en = 1'b0; flush = 1'b0;
    model_reset();
    clear_collect();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (obs_vec() !== 10'b01_00_00_00_00) begin
      tests_failed++; $display("FAIL reset_out got=%b exp=%b", obs_vec(), 10'b01_00_00_00_00);
    end
    tests_run++;
    if ({par_ready_a, par_ready_b} !== 2'b11) begin
      tests_failed++; $display("FAIL reset_ready got=%b exp=11", {par_ready_a, par_ready_b});
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    clear_collect();
    for (int i = 0; i < 11; i++) begin
      clk_cycle(i == 0, 8'hC1, 1'b1, 1'b0);
      tests_run++;
      if (got_ready !== {2{e_ready}} || obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL single cyc=%0d ready=%b/%b out=%b exp=%b", i, got_ready, e_ready, obs_vec(), exp_vec());
      end
      tests_run++;
      if ({ser_first_a, ser_last_a} !== ((i == 1) ? 2'b10 : (i == 8) ? 2'b01 : 2'b00)) begin
        tests_failed++; $display("FAIL single_markers cyc=%0d got=%b", i, {ser_first_a, ser_last_a});
      end
    end
    tests_run++;
    if ({col_a[7:0], col_b[7:0], n_valid[7:0]} !== {8'hC1, 8'h83, 8'd8}) begin
      tests_failed++; $display("FAIL single_bits got a=%h b=%h n=%0d exp a=c1 b=83 n=8", col_a[7:0], col_b[7:0], n_valid);
    end
  endtask

  task automatic test_back_to_back();
    clear_collect();
    for (int i = 0; i < 19; i++) begin
      clk_cycle(i <= 8, (i == 0) ? 8'hFF : 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (got_ready !== {2{e_ready}} || obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL b2b cyc=%0d ready=%b/%b out=%b exp=%b", i, got_ready, e_ready, obs_vec(), exp_vec());
      end
      if (i <= 8) begin
        tests_run++;
        if (got_ready !== {2{(i == 0 || i == 8)}}) begin
          tests_failed++; $display("FAIL b2b_ready cyc=%0d got=%b", i, got_ready);
        end
      end
      tests_run++;
      if (ser_valid_a !== (i >= 1 && i <= 16)) begin
        tests_failed++; $display("FAIL b2b_valid cyc=%0d got=%b", i, ser_valid_a);
      end
    end
    tests_run++;
    if ({col_a, col_b, n_first[7:0]} !== {16'hFF00, 16'hFF00, 8'd2}) begin
      tests_failed++; $display("FAIL b2b_bits got a=%h b=%h firsts=%0d exp ff00 ff00 2", col_a, col_b, n_first);
    end
  endtask

  task automatic test_bit_en();
    int busy_cycles;
    busy_cycles = 0;
    clear_collect();
    for (int i = 0; i < 40; i++) begin
      clk_cycle(i == 0, 8'hA5, (i % 4) == 0, 1'b0);
      if (busy_a) busy_cycles++;
      tests_run++;
      if (got_ready !== {2{e_ready}} || obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL biten cyc=%0d ready=%b/%b out=%b exp=%b", i, got_ready, e_ready, obs_vec(), exp_vec());
      end
    end
    tests_run++;
    if ({col_a[7:0], col_b[7:0], n_valid[7:0], busy_cycles[7:0]} !== {8'hA5, 8'hA5, 8'd8, 8'd32}) begin
      tests_failed++;
      $display("FAIL biten_summary got a=%h b=%h n=%0d busy=%0d exp a5 a5 8 32", col_a[7:0], col_b[7:0], n_valid, busy_cycles);
    end
  endtask

  task automatic test_flush();
    clear_collect();
    for (int i = 0; i < 17; i++) begin
      clk_cycle(i == 0 || i == 4 || i == 6, (i == 0) ? 8'hC1 : (i == 4) ? 8'hFF : 8'h4D, i != 5, i == 4);
      tests_run++;
      if (got_ready !== {2{e_ready}} || obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL flush cyc=%0d ready=%b/%b out=%b exp=%b", i, got_ready, e_ready, obs_vec(), exp_vec());
      end
      if (i == 4) begin
        tests_run++;
        if ({got_ready, ser_o_a, ser_o_b, ser_valid_a, busy_a, busy_b} !== 7'b00_01_0_00) begin
          tests_failed++;
          $display("FAIL flush_edge got ready=%b ser=%b%b valid=%b busy=%b%b", got_ready, ser_o_a, ser_o_b, ser_valid_a, busy_a, busy_b);
        end
      end
      if (i == 5) begin
        tests_run++;
        if ({got_ready, n_last[3:0], n_valid[3:0]} !== {2'b11, 4'd0, 4'd3}) begin
          tests_failed++; $display("FAIL flush_after got ready=%b lasts=%0d bits=%0d exp 11 0 3", got_ready, n_last, n_valid);
        end
        clear_collect();
      end
    end
    tests_run++;
    if ({col_a[7:0], col_b[7:0], n_first[3:0], n_last[3:0]} !== {8'h4D, 8'hB2, 4'd1, 4'd1}) begin
      tests_failed++; $display("FAIL flush_next got a=%h b=%h f=%0d l=%0d exp 4d b2 1 1", col_a[7:0], col_b[7:0], n_first, n_last);
    end
  endtask

  task automatic test_reset_mid();
    clear_collect();
    for (int i = 0; i < 3; i++) clk_cycle(i == 0, 8'hC1, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (obs_vec() !== exp_vec()) begin
      tests_failed++; $display("FAIL rst_mid got=%b exp=%b", obs_vec(), exp_vec());
    end
    #2 rst_n = 1'b1;
    clear_collect();
    for (int i = 0; i < 11; i++) begin
      clk_cycle(i == 0, 8'h3C, 1'b1, 1'b0);
      tests_run++;
      if (got_ready !== {2{e_ready}} || obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL rst_word cyc=%0d ready=%b/%b out=%b exp=%b", i, got_ready, e_ready, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        tests_run++;
        if ({ser_valid_a, ser_first_a, ser_o_a} !== 3'b110) begin
          tests_failed++; $display("FAIL rst_first got=%b exp=110", {ser_valid_a, ser_first_a, ser_o_a});
        end
      end
    end
    tests_run++;
    if ({col_a[7:0], col_b[7:0]} !== {8'h3C, 8'h3C}) begin
      tests_failed++; $display("FAIL rst_bits got a=%h b=%h exp 3c 3c", col_a[7:0], col_b[7:0]);
    end
  endtask

  task automatic test_random();
    logic v, be, fl;
    logic [7:0] d;
    clear_collect();
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      be = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 39) == 0);
      d  = 8'($urandom);
      clk_cycle(v, d, be, fl);
      tests_run++;
      if (got_ready !== {2{e_ready}} || obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random cyc=%0d ready=%b/%b out=%b exp=%b", i, got_ready, e_ready, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bit_en();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
